gf128_inv: RTL and testbench

- Iterative GF(2^128) inverter for the AES-GCM datapath; the inverse direction of the existing combinational GF_128_MUL.
- Computes a^-1 = a^(2^128-2) by Fermat exponentiation, using one shared GF_128_MUL instance over multiple cycles.
- Uses the same field convention as GF_128_MUL: polynomial basis, bit 0 = x^0, reduction x^128+x^7+x^2+x+1 (128'h87).
- Serves key-schedule and test utilities, such as hash-key checks and the division operations needed for GHASH verification.

---
 rtl/gf128_pkg.sv | 18 +
 rtl/GF_128_MUL.sv | 27 ++
 rtl/gf128_inv.sv | 89 ++++++++
 tb/tb_gf128_inv.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gf128_pkg.sv
// Shared field constants and FSM encodings for the GF(2^128) inverter.
// Polynomial basis, bit 0 = x^0, reduction x^128 + x^7 + x^2 + x + 1.
package gf128_pkg;

    localparam logic [127:0] GF128_POLY     = 128'h87;
    localparam logic [127:0] GF128_ONE      = 128'h1;
    localparam int           GF128_INV_ITER = 126;
    localparam int           GF128_INV_LAT  = 253;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t SQR  = 3'd1;
    localparam state_t MUL  = 3'd2;
    localparam state_t FIN  = 3'd3;
    localparam state_t DONE = 3'd4;

endpackage

// File: rtl/GF_128_MUL.sv
// Combinational GF(2^128) multiplier, shift-and-add with on-the-fly reduction.
// Zero latency; no handshake.
module GF_128_MUL
    import gf128_pkg::*;
(
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic [127:0] product
);

    logic [127:0] acc;
    logic [127:0] v;

    always_comb begin
        acc = '0;
        v   = a;
        for (int i = 0; i < 128; i++) begin
            if (b[i]) begin
                acc = acc ^ v;
            end
            // v <- v * x mod P
            v = {v[126:0], 1'b0} ^ (v[127] ? GF128_POLY : 128'h0);
        end
        product = acc;
    end

endmodule

// File: rtl/gf128_inv.sv
// Iterative GF(2^128) inverter, a^(2^128-2) via one shared multiplier; 253 cycles after accept.
// Result and zero_err hold in DONE until out_ready; in_ready only in IDLE.
module gf128_inv
    import gf128_pkg::*;
#(
    parameter int CNT_W  = 7,
    parameter int N_ITER = GF128_INV_ITER
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] result,
    output logic         zero_err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

    state_t             state;
    logic [127:0]       a_reg;
    logic [127:0]       t;
    logic [CNT_W-1:0]   cnt;
    logic               zflag;
    logic [127:0]       mb;
    logic [127:0]       prod;

    // Only MUL multiplies by the operand; every other state squares t.
    assign mb = (state == MUL) ? a_reg : t;

    GF_128_MUL u_mul (
        .a       (t),
        .b       (mb),
        .product (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            t     <= '0;
            cnt   <= '0;
            zflag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        t     <= a;
                        cnt   <= '0;
                        zflag <= (a == 128'h0);
                        state <= SQR;
                    end
                end
                SQR: begin
                    t     <= prod;
                    state <= MUL;
                end
                MUL: begin
                    t <= prod;
                    if (cnt == LAST) begin
                        state <= FIN;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= SQR;
                    end
                end
                FIN: begin
                    t     <= prod;
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = (state == DONE) ? t : 128'h0;
    assign zero_err  = (state == DONE) & zflag;

endmodule

// File: tb/tb_gf128_inv.sv
// Bench for gf128_inv: directed vectors, random operands against a carry-less
// reference, backpressure, busy-time input noise and asynchronous reset abort.
module tb_gf128_inv;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;
    logic         zero_err;

    int checks = 0;
    int errors = 0;

    gf128_inv dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero_err  (zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full carry-less product, then fold the upper half back with the modulus.
    function automatic logic [127:0] ref_mul(input logic [127:0] x, input logic [127:0] y);
        logic [254:0] p;
        logic [254:0] modulus;
        p       = '0;
        modulus = 255'({1'b1, 128'h87});
        for (int i = 0; i < 128; i++) begin
            if (y[i]) p = p ^ (255'(x) << i);
        end
        for (int i = 254; i >= 128; i--) begin
            if (p[i]) p = p ^ (modulus << (i - 128));
        end
        return p[127:0];
    endfunction

    // x^(2^128-2) = prod_{i=1..127} x^(2^i)
    function automatic logic [127:0] ref_inv(input logic [127:0] x);
        logic [127:0] r;
        logic [127:0] s;
        r = 128'h1;
        s = x;
        for (int i = 1; i < 128; i++) begin
            s = ref_mul(s, s);
            r = ref_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold = cycles out_ready stays low after out_valid.
    task automatic run_op(input logic [127:0] op, input int hold,
                          output logic [127:0] res, output logic z, output int lat);
        @(negedge clk);
        check("in_ready_idle", 128'(in_ready), 128'd1);
        a        = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 400) begin
            a        = rand128();
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 128'(lat), 128'd253);
        res = result;
        z   = zero_err;
        for (int i = 0; i < hold; i++) begin
            a        = rand128();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_result", result, res);
            check("bp_flags", {125'h0, out_valid, in_ready, zero_err}, {125'h0, 1'b1, 1'b0, z});
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("handoff", {126'h0, out_valid, in_ready}, 128'b01);
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] op;
        logic         z;
        int           lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        #12;
        check("rst_in_ready",  128'(in_ready),  128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_result",    result,          128'h0);
        check("rst_zero_err",  128'(zero_err),  128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'd1);

        run_op(128'h1, 0, res, z, lat);
        check("inv_one", res, 128'h1);
        check("inv_one_z", 128'(z), 128'd0);

        run_op(128'h2, 0, res, z, lat);
        check("inv_x", res, 128'h80000000000000000000000000000043);
        op = res;
        run_op(op, 0, res, z, lat);
        check("inv_inv_x", res, 128'h2);

        run_op(128'h0, 0, res, z, lat);
        check("inv_zero", res, 128'h0);
        check("inv_zero_z", 128'(z), 128'd1);

        op = rand128() | 128'h1;
        run_op(op, 10, res, z, lat);
        check("bp_value", res, ref_inv(op));

        for (int n = 0; n < 40; n++) begin
            op = rand128();
            if (op == 128'h0) op = 128'h1;
            run_op(op, n % 3, res, z, lat);
            check("rand_inv", res, ref_inv(op));
            check("rand_prod", ref_mul(op, res), 128'h1);
            check("rand_z", 128'(z), 128'd0);
        end

        // Abort an operation with an asynchronous reset partway through.
        @(negedge clk);
        a        = rand128() | 128'h1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (99) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_in_ready",  128'(in_ready),  128'd1);
        check("abort_result",    result,          128'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(128'h1, 0, res, z, lat);
        check("after_abort", res, 128'h1);
        check("after_abort_z", 128'(z), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
